// File: rtl/cnn_load_sequencer.sv
// Streams kernels, FC weights and an image into packed CNN input buses, kicks the
// CNN, waits (with timeout) for it to go idle and captures its result.
module cnn_load_sequencer #(
  parameter int unsigned IMAGE_WIDTH       = 12,
  parameter int unsigned IMAGE_HEIGHT      = 12,
  parameter int unsigned PIXEL_WIDTH       = 2,
  parameter int unsigned KERNEL_SIZE       = 3,
  parameter int unsigned NUM_FEATURES      = 2,
  parameter int unsigned WEIGHT_WIDTH      = 2,
  parameter int unsigned FLATTENED_LENGTH  = 50,
  parameter int unsigned FC_WIDTH          = 8,
  parameter int unsigned OUTPUT_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 4096
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic                                              reload_weights,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [FC_WIDTH-1:0]                               in_data,
  output logic [PIXEL_WIDTH*IMAGE_HEIGHT*IMAGE_WIDTH-1:0]   image_input,
  output logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]   feature_weights_input,
  output logic [$clog2(NUM_FEATURES):0]                     feature_writeAddr,
  output logic                                              feature_WrEn,
  output logic [FC_WIDTH*FLATTENED_LENGTH-1:0]              fullyconnected_weights_input,
  output logic                                              fullyconnected_WrEn,
  output logic                                              convolution_enable,
  input  logic                                              cnn_idle,
  input  logic [OUTPUT_DATA_WIDTH-1:0]                      cnn_output,
  output logic [OUTPUT_DATA_WIDTH-1:0]                      result,
  output logic                                              result_valid,
  output logic                                              busy,
  output logic                                              timeout_err
);

  localparam int unsigned KER_N   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned IMG_N   = IMAGE_HEIGHT * IMAGE_WIDTH;
  localparam int unsigned FA_W    = $clog2(NUM_FEATURES) + 1;
  localparam int unsigned MAX_A   = (KER_N > FLATTENED_LENGTH) ? KER_N : FLATTENED_LENGTH;
  localparam int unsigned CNT_MAX = (MAX_A > IMG_N) ? MAX_A : IMG_N;
  localparam int unsigned IDX_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD_FEAT = 4'd1;
  localparam logic [3:0] S_WR_FEAT   = 4'd2;
  localparam logic [3:0] S_LOAD_FC   = 4'd3;
  localparam logic [3:0] S_WR_FC     = 4'd4;
  localparam logic [3:0] S_LOAD_IMG  = 4'd5;
  localparam logic [3:0] S_KICK      = 4'd6;
  localparam logic [3:0] S_WAIT_CNN  = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [IDX_W-1:0] elem_q, elem_d;
  logic [FA_W-1:0]  feat_d;
  logic             wr_q, wr_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic             take, capture, expire, load_d;

  // in_ready is only ever high in a load state, so a handshake implies one
  assign take = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    feat_d  = feature_writeAddr;
    wr_d    = wr_q;
    wait_d  = wait_q;
    capture = 1'b0;
    expire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = reload_weights ? S_LOAD_FEAT : S_LOAD_IMG;
          elem_d  = '0;
          feat_d  = '0;
          wr_d    = 1'b0;
          wait_d  = '0;
        end
      end
      S_LOAD_FEAT: begin
        if (take) begin
          if (elem_q == IDX_W'(KER_N - 1)) begin
            elem_d  = '0;
            state_d = S_WR_FEAT;
          end else begin
            elem_d = elem_q + IDX_W'(1);
          end
        end
      end
      S_WR_FEAT: begin
        wr_d = ~wr_q;
        if (wr_q) begin
          if (feature_writeAddr < FA_W'(NUM_FEATURES - 1)) begin
            feat_d  = feature_writeAddr + FA_W'(1);
            state_d = S_LOAD_FEAT;
          end else begin
            state_d = S_LOAD_FC;
          end
        end
      end
      S_LOAD_FC: begin
        if (take) begin
          if (elem_q == IDX_W'(FLATTENED_LENGTH - 1)) begin
            elem_d  = '0;
            state_d = S_WR_FC;
          end else begin
            elem_d = elem_q + IDX_W'(1);
          end
        end
      end
      S_WR_FC: begin
        wr_d = ~wr_q;
        if (wr_q) state_d = S_LOAD_IMG;
      end
      S_LOAD_IMG: begin
        if (take) begin
          if (elem_q == IDX_W'(IMG_N - 1)) begin
            elem_d  = '0;
            state_d = S_KICK;
          end else begin
            elem_d = elem_q + IDX_W'(1);
          end
        end
      end
      S_KICK: begin
        wait_d  = '0;
        state_d = S_WAIT_CNN;
      end
      S_WAIT_CNN: begin
        // first two cycles give the CNN time to leave its IDLE state
        if ((wait_q >= TO_W'(2)) && cnn_idle) begin
          capture = 1'b1;
          wait_d  = '0;
          state_d = S_DONE;
        end else if (wait_q >= TO_W'(TIMEOUT_CYCLES - 1)) begin
          expire  = 1'b1;
          wait_d  = '0;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign load_d = (state_d == S_LOAD_FEAT) | (state_d == S_LOAD_FC) | (state_d == S_LOAD_IMG);

  // state, counters, strobes and packed buses; strobes decode the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                      <= S_IDLE;
      elem_q                       <= '0;
      wr_q                         <= 1'b0;
      wait_q                       <= '0;
      in_ready                     <= 1'b0;
      busy                         <= 1'b0;
      result_valid                 <= 1'b0;
      timeout_err                  <= 1'b0;
      feature_WrEn                 <= 1'b1;
      fullyconnected_WrEn          <= 1'b1;
      convolution_enable           <= 1'b1;
      feature_writeAddr            <= '0;
      result                       <= '0;
      image_input                  <= '0;
      feature_weights_input        <= '0;
      fullyconnected_weights_input <= '0;
    end else begin
      state_q             <= state_d;
      elem_q              <= elem_d;
      wr_q                <= wr_d;
      wait_q              <= wait_d;
      feature_writeAddr   <= feat_d;
      in_ready            <= load_d;
      busy                <= (state_d != S_IDLE);
      result_valid        <= (state_d == S_DONE);
      feature_WrEn        <= (state_d != S_WR_FEAT);
      fullyconnected_WrEn <= (state_d != S_WR_FC);
      convolution_enable  <= (state_d != S_KICK);
      if (capture) result <= cnn_output;
      if (expire) timeout_err <= 1'b1;
      else if ((state_q == S_IDLE) && start) timeout_err <= 1'b0;
      if (take && (state_q == S_LOAD_FEAT)) begin
        for (int i = 0; i < int'(KER_N); i++)
          if (elem_q == IDX_W'(i))
            feature_weights_input[(KER_N-1-i)*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= in_data[WEIGHT_WIDTH-1:0];
      end
      if (take && (state_q == S_LOAD_FC)) begin
        for (int i = 0; i < int'(FLATTENED_LENGTH); i++)
          if (elem_q == IDX_W'(i))
            fullyconnected_weights_input[(FLATTENED_LENGTH-1-i)*FC_WIDTH +: FC_WIDTH] <= in_data;
      end
      if (take && (state_q == S_LOAD_IMG)) begin
        for (int i = 0; i < int'(IMG_N); i++)
          if (elem_q == IDX_W'(i))
            image_input[(IMG_N-1-i)*PIXEL_WIDTH +: PIXEL_WIDTH] <= in_data[PIXEL_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_cnn_load_sequencer.sv
// Scoreboard bench for cnn_load_sequencer: stimulus queues expected strobe/kick/result
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_cnn_load_sequencer;

  localparam int KER_BITS = 18;
  localparam int FC_BITS  = 400;
  localparam int IMG_BITS = 288;
  localparam int IMG_N    = 144;
  localparam int FC_N     = 50;
  localparam int TMO_LAT  = 4097;

  localparam int K_FEAT = 0;
  localparam int K_FC   = 1;
  localparam int K_KICK = 2;
  localparam int K_RES  = 3;
  localparam int K_TMO  = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                reload_weights = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [7:0]          in_data = '0;
  logic [IMG_BITS-1:0] image_input;
  logic [KER_BITS-1:0] feature_weights_input;
  logic [1:0]          feature_writeAddr;
  logic                feature_WrEn;
  logic [FC_BITS-1:0]  fullyconnected_weights_input;
  logic                fullyconnected_WrEn;
  logic                convolution_enable;
  logic                cnn_idle = 1'b1;
  logic [31:0]         cnn_output = '0;
  logic [31:0]         result;
  logic                result_valid;
  logic                busy;
  logic                timeout_err;

  cnn_load_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .reload_weights(reload_weights),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .image_input(image_input), .feature_weights_input(feature_weights_input),
    .feature_writeAddr(feature_writeAddr), .feature_WrEn(feature_WrEn),
    .fullyconnected_weights_input(fullyconnected_weights_input),
    .fullyconnected_WrEn(fullyconnected_WrEn), .convolution_enable(convolution_enable),
    .cnn_idle(cnn_idle), .cnn_output(cnn_output), .result(result),
    .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;
    logic [511:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   kick_cyc = 0;
  int   cdly = 0;
  bit   hang = 1'b0;
  bit   tmo_prev = 1'b0;

  // kernel 0 = {1,-1,1,-1,1,-1,1,-1,1}, kernel 1 = all ones, 2-bit fields, element 0 MSB
  localparam logic [KER_BITS-1:0] K0 = 18'h1DDDD;
  localparam logic [KER_BITS-1:0] K1 = 18'h15555;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  function automatic void push(input int k, input logic [511:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sbq.push_back(e);
  endfunction

  task automatic sb_pop(input int kind, input string nm, input logic [511:0] act);
    exp_t e;
    if (sbq.size() == 0) begin
      n_total++;
      $display("FAIL sb_%s unexpected event act=%0h exp=none", nm, act);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_kind"}, 512'(kind), 512'(e.kind));
      if (e.kind == kind) chk(nm, act, e.val);
    end
  endtask

  function automatic logic [7:0] fc_word(input int i);
    return 8'(i * 3 + 1);
  endfunction

  function automatic logic [7:0] pix_word(input int i, input int s);
    return 8'(i * s + 7 * s + 64);
  endfunction

  function automatic logic [FC_BITS-1:0] fc_ref();
    logic [FC_BITS-1:0] r = '0;
    for (int i = 0; i < FC_N; i++) r[(FC_N-1-i)*8 +: 8] = fc_word(i);
    return r;
  endfunction

  function automatic logic [IMG_BITS-1:0] img_ref(input int s);
    logic [IMG_BITS-1:0] r = '0;
    logic [7:0] w;
    for (int i = 0; i < IMG_N; i++) begin
      w = pix_word(i, s);
      r[(IMG_N-1-i)*2 +: 2] = w[1:0];
    end
    return r;
  endfunction

  // CNN model: drops idle on the kick, raises it again four cycles later unless hung
  always @(negedge clk) begin
    if (rst) begin
      cnn_idle = 1'b1;
      cdly     = 0;
    end else if (!convolution_enable) begin
      cnn_idle = 1'b0;
      cdly     = 4;
    end else if (cdly > 0) begin
      cdly--;
      if (cdly == 0 && !hang) cnn_idle = 1'b1;
    end
  end

  // monitor: every strobe cycle / kick / result / timeout edge consumes one expectation
  always @(negedge clk) begin
    cyc++;
    if (in_valid && in_ready) hs_cnt++;
    if (!feature_WrEn) sb_pop(K_FEAT, "feat_wr", 512'({feature_writeAddr, feature_weights_input}));
    if (!fullyconnected_WrEn) sb_pop(K_FC, "fc_wr", 512'(fullyconnected_weights_input));
    if (!convolution_enable) begin
      kick_cyc = cyc;
      sb_pop(K_KICK, "kick_img", 512'(image_input));
    end
    if (result_valid) sb_pop(K_RES, "result", 512'(result));
    if (timeout_err && !tmo_prev) sb_pop(K_TMO, "timeout_lat", 512'(cyc - kick_cyc));
    tmo_prev = timeout_err;
  end

  task automatic send(input logic [7:0] d, input bit gap);
    int w = 0;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 100) begin
        n_total++;
        $display("FAIL in_ready_wait act=stalled exp=ready");
        return;
      end
    end
    @(posedge clk); #1;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start(input bit reload, input bit with_word, input logic [7:0] w);
    start          = 1'b1;
    reload_weights = reload;
    if (with_word) begin
      in_valid = 1'b1;
      in_data  = w;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    n_total++;
    $display("FAIL wait_idle act=busy exp=idle");
  endtask

  task automatic send_kernels();
    for (int i = 0; i < 9; i++) send((i % 2 == 0) ? 8'h01 : 8'hFF, 1'b0);
    for (int i = 0; i < 9; i++) send(8'h01, 1'b0);
  endtask

  task automatic push_weights();
    push(K_FEAT, 512'({2'd0, K0}));
    push(K_FEAT, 512'({2'd0, K0}));
    push(K_FEAT, 512'({2'd1, K1}));
    push(K_FEAT, 512'({2'd1, K1}));
  endtask

  task automatic full_job(input logic [31:0] v, input int s);
    int h0 = hs_cnt;
    push_weights();
    push(K_FC, 512'(fc_ref()));
    push(K_FC, 512'(fc_ref()));
    push(K_KICK, 512'(img_ref(s)));
    push(K_RES, 512'(v));
    cnn_output = v;
    do_start(1'b1, 1'b1, 8'h01);
    send_kernels();
    for (int i = 0; i < FC_N; i++) send(fc_word(i), 1'b0);
    for (int i = 0; i < IMG_N; i++) send(pix_word(i, s), 1'b0);
    in_valid = 1'b0;
    wait_idle(200);
    chk("full_words", 512'(hs_cnt - h0), 512'(18 + FC_N + IMG_N));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, 512'(in_ready), 512'(0));
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_result_valid"}, 512'(result_valid), 512'(0));
    chk({tag, "_timeout_err"}, 512'(timeout_err), 512'(0));
    chk({tag, "_strobes"}, 512'({feature_WrEn, fullyconnected_WrEn, convolution_enable}), 512'(3'b111));
    chk({tag, "_addr"}, 512'(feature_writeAddr), 512'(0));
    chk({tag, "_kernel"}, 512'(feature_weights_input), 512'(0));
    chk({tag, "_fc"}, 512'(fullyconnected_weights_input), 512'(0));
    chk({tag, "_image"}, 512'(image_input), 512'(0));
    chk({tag, "_result"}, 512'(result), 512'(0));
  endtask

  initial begin
    int h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // full job with a word already offered in the start cycle
    full_job(32'd37, 1);
    chk("job1_kernel", 512'(feature_weights_input), 512'(K1));
    chk("job1_fc", 512'(fullyconnected_weights_input), 512'(fc_ref()));
    chk("job1_result", 512'(result), 512'(37));

    // image-only job, with a start (reload=1) pulsed while busy
    h0 = hs_cnt;
    push(K_KICK, 512'(img_ref(5)));
    push(K_RES, 512'(32'd1234));
    cnn_output = 32'd1234;
    do_start(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < IMG_N; i++) begin
      send(pix_word(i, 5), 1'b0);
      if (i == 9) begin
        in_valid = 1'b0;
        start = 1'b1;
        reload_weights = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    wait_idle(200);
    chk("job2_words", 512'(hs_cnt - h0), 512'(IMG_N));
    chk("job2_kernel_held", 512'(feature_weights_input), 512'(K1));
    chk("job2_fc_held", 512'(fullyconnected_weights_input), 512'(fc_ref()));

    // backpressure: in_valid toggles every cycle
    h0 = hs_cnt;
    push(K_KICK, 512'(img_ref(11)));
    push(K_RES, 512'(32'hFFFF_FFF0));
    cnn_output = 32'hFFFF_FFF0;
    do_start(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < IMG_N; i++) send(pix_word(i, 11), 1'b1);
    in_valid = 1'b0;
    wait_idle(200);
    chk("bp_words", 512'(hs_cnt - h0), 512'(IMG_N));
    chk("bp_image", 512'(image_input), 512'(img_ref(11)));

    // timeout with the CNN stuck busy
    hang = 1'b1;
    push(K_KICK, 512'(img_ref(3)));
    push(K_TMO, 512'(TMO_LAT));
    do_start(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < IMG_N; i++) send(pix_word(i, 3), 1'b0);
    in_valid = 1'b0;
    wait_idle(4300);
    chk("tmo_flag", 512'(timeout_err), 512'(1));
    chk("tmo_busy", 512'(busy), 512'(0));
    hang = 1'b0;
    push(K_KICK, 512'(img_ref(2)));
    push(K_RES, 512'(32'd99));
    cnn_output = 32'd99;
    do_start(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("tmo_cleared", 512'(timeout_err), 512'(0));
    @(posedge clk); #1;
    for (int i = 0; i < IMG_N; i++) send(pix_word(i, 2), 1'b0);
    in_valid = 1'b0;
    wait_idle(200);
    chk("tmo_next_result", 512'(result), 512'(99));

    // reset after 20 FC words, then a clean full job
    push_weights();
    do_start(1'b1, 1'b0, 8'h00);
    send_kernels();
    for (int i = 0; i < 20; i++) send(fc_word(i), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    reset_checks("midrst");
    rst = 1'b0;
    chk("midrst_sb_drained", 512'(sbq.size()), 512'(0));
    full_job(32'd555, 7);
    chk("post_rst_result", 512'(result), 512'(555));

    repeat (5) @(negedge clk);
    chk("sb_empty", 512'(sbq.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
